// File: rtl/mux2to1_8bit_pkg.sv
// Shared types and widths for the registered byte-wide 2:1 selector.
//   BYTE_W : native data width of the selector datapath
//   byte_t : byte-wide data word
package mux2to1_8bit_pkg;

  localparam int BYTE_W = 8;

  typedef logic [BYTE_W-1:0] byte_t;

endpackage

// File: rtl/mux2to1_8bit_if.sv
// Bus bundle for the registered 2:1 selector.
//   sel     : source select (0 -> in0, 1 -> in1)
//   in0/in1 : data sources
//   mux_out : registered selected data
// master drives sel/in0/in1 and observes mux_out; slave is the selector.
interface mux2to1_8bit_if #(
  parameter int WIDTH = mux2to1_8bit_pkg::BYTE_W
);

  logic             sel;
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] mux_out;

  modport master (
    output sel,
    output in0,
    output in1,
    input  mux_out
  );

  modport slave (
    input  sel,
    input  in0,
    input  in1,
    output mux_out
  );

endinterface

// File: rtl/mux2to1_8bit_bit.sv
// Combinational single-bit 2:1 selector.
//   sel : 0 passes a, 1 passes b
//   a   : source 0 bit
//   b   : source 1 bit
//   y   : selected bit
// An X on sel propagates to y in simulation wherever a and b differ.
module mux_2to1_1bit (
  input  logic sel,
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/mux2to1_8bit.sv
// Registered WIDTH-bit 2:1 selector: each rising clk edge captures
// in1 when sel=1, otherwise in0, into the output register.
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low clear of the output register
//   bus   : slave side of mux2to1_8bit_if (sel, in0, in1 in; mux_out out)
module mux2to1_8bit
  import mux2to1_8bit_pkg::*;
#(
  parameter int WIDTH = BYTE_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mux2to1_8bit_if.slave        bus
);

  logic [WIDTH-1:0] w_mux_d;
  logic [WIDTH-1:0] r_mux_out;

  // One bit-slice selector per data bit; the sources are never combined.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    mux_2to1_1bit u_bit (
      .sel (bus.sel),
      .a   (bus.in0[gi]),
      .b   (bus.in1[gi]),
      .y   (w_mux_d[gi])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mux_out <= '0;
    end else begin
      r_mux_out <= w_mux_d;
    end
  end

  assign bus.mux_out = r_mux_out;

endmodule

// File: tb/tb_mux2to1_8bit.sv
module tb_mux2to1_8bit;

  typedef struct {
    logic [7:0] v;
    string      name;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;
  exp_t sb_q[$];

  mux2to1_8bit_if #(.WIDTH(8)) bus ();

  mux2to1_8bit #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: mux_out=%02h expected=%02h", name, act, req);
  endtask

  // Drive one vector between edges and queue the value expected after the
  // next rising edge.
  task automatic step(input logic s, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] exp_v, input string name);
    exp_t e;
    @(negedge clk);
    bus.sel = s;
    bus.in0 = a;
    bus.in1 = b;
    e.v = exp_v;
    e.name = name;
    sb_q.push_back(e);
  endtask

  // Monitor: the output is presented every cycle, so compare once per edge
  // whenever an expectation is pending.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check(e.name, bus.mux_out, e.v);
      end
    end
  end

  initial begin
    exp_t e;
    int   budget;
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    bus.sel  = 1'b1;
    bus.in0  = 8'h5F;
    bus.in1  = 8'hC8;

    #1;
    check("reset_initial", bus.mux_out, 8'h00);

    for (int i = 0; i < 3; i++) step(1'b1, 8'h5F, 8'hC8, 8'h00, "reset_hold");

    @(negedge clk);
    rst_n   = 1'b1;
    bus.sel = 1'b0;
    bus.in0 = 8'h00;
    bus.in1 = 8'h5F;
    e.v = 8'h00;
    e.name = "release_sel0";
    sb_q.push_back(e);

    step(1'b0, 8'h00, 8'hEA, 8'h00, "sel0_in1_change");
    step(1'b1, 8'h5F, 8'hC8, 8'hC8, "sel1_c8");
    step(1'b1, 8'h5F, 8'h91, 8'h91, "sel1_91");
    step(1'b1, 8'hC8, 8'h1D, 8'h1D, "sel1_1d");
    step(1'b0, 8'hC8, 8'hEA, 8'hC8, "switch_to0_c8");
    step(1'b0, 8'h91, 8'hEA, 8'h91, "sel0_91");
    step(1'b1, 8'h91, 8'h74, 8'h74, "switch_to1_74");
    step(1'b1, 8'h1D, 8'hA8, 8'hA8, "sel1_a8");
    step(1'b1, 8'hEA, 8'hA8, 8'hA8, "in0_isolation");

    // Async clear between edges: output must drop without a clock edge.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_mid", bus.mux_out, 8'h00);

    step(1'b1, 8'hEA, 8'hA8, 8'h00, "reset_edge_ignored");

    @(negedge clk);
    rst_n = 1'b1;
    e.v = 8'hA8;
    e.name = "release_reload";
    sb_q.push_back(e);

    step(1'b0, 8'h3C, 8'hA8, 8'h3C, "final_sel0");

    budget = 10;
    while (sb_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #2;
    if (sb_q.size() > 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: pending=%0d expected=0", sb_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
